// File: rtl/adc_seq_ctrl.sv
// Conversion sequencer for a parallel-output SAR ADC behind an analog mux.
// Scans enabled channels in ascending order, runs the CONVST/BUSY/RD handshake
// and streams {last_of_frame, ch, sample} words over a valid/ready port.
module adc_seq_ctrl #(
    parameter int unsigned DATA_W        = 12,
    parameter int unsigned NCH           = 8,
    parameter int unsigned CONVST_CYCLES = 2,
    parameter int unsigned BLANK_CYCLES  = 4,
    parameter int unsigned RD_CYCLES     = 3,
    parameter int unsigned TIMEOUT       = 1023,
    localparam int unsigned CH_W         = $clog2(NCH)
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic                     cfg_start,
    input  logic                     cfg_stop,
    input  logic [NCH-1:0]           cfg_ch_mask,
    input  logic [15:0]              cfg_frames,
    input  logic [7:0]               cfg_settle,
    output logic [CH_W-1:0]          adc_ch,
    output logic                     adc_convst,
    input  logic                     adc_busy,
    output logic                     adc_rd_n,
    input  logic [DATA_W-1:0]        adc_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W+CH_W:0]     m_data,
    output logic                     st_busy,
    output logic                     st_done,
    output logic                     st_timeout,
    output logic [15:0]              st_frame_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] C_CONVST_LAST = CNT_W'(CONVST_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_BLANK       = CNT_W'(BLANK_CYCLES);
    localparam logic [CNT_W-1:0] C_RD_LAST     = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST     = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StSelect, StSettle, StConvst, StWaitBusy, StRead, StPush, StNext
    } state_e;

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt;
    logic [NCH-1:0]      r_mask;
    logic [15:0]         r_frames;
    logic [7:0]          r_settle;
    logic [CH_W-1:0]     r_ch;
    logic                r_stop;
    logic [15:0]         r_frame_cnt;
    logic                r_busy_meta, r_busy_sync;

    logic                r_convst, r_rd_n, r_valid, r_st_busy, r_done, r_timeout;
    logic [DATA_W+CH_W:0] r_mdata;

    logic                w_convst_d, w_rd_n_d, w_valid_d, w_st_busy_d, w_done_d, w_timeout_d;
    logic [DATA_W+CH_W:0] w_mdata_d;

    logic [CH_W-1:0]     w_cfg_first, w_first, w_next;
    logic                w_has_next, w_is_last;
    logic                w_start_ok, w_start_empty;
    logic                w_busy_done, w_timeout_hit, w_finish, w_stop_any;
    logic [15:0]         w_frame_inc;

    assign w_start_ok    = (r_state == StIdle) && cfg_start && (cfg_ch_mask != '0);
    assign w_start_empty = (r_state == StIdle) && cfg_start && (cfg_ch_mask == '0);
    assign w_busy_done   = (r_cnt >= C_BLANK) && !r_busy_sync;
    assign w_timeout_hit = (r_cnt == C_TO_LAST);
    assign w_is_last     = !w_has_next;
    assign w_stop_any    = r_stop | cfg_stop;
    assign w_frame_inc   = (r_frame_cnt == 16'hFFFF) ? r_frame_cnt : r_frame_cnt + 16'd1;
    // A frame only counts once its last channel is done; stop ends the run regardless.
    assign w_finish      = w_stop_any ||
                           (w_is_last && (r_frames != 16'd0) && (w_frame_inc == r_frames));

    // Channel search: lowest enabled channel and next enabled channel above r_ch.
    always_comb begin
        w_cfg_first = '0;
        w_first     = '0;
        w_next      = '0;
        w_has_next  = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cfg_ch_mask[i]) w_cfg_first = CH_W'(i);
            if (r_mask[i]) w_first = CH_W'(i);
            if (r_mask[i] && (i > int'(r_ch))) begin
                w_next     = CH_W'(i);
                w_has_next = 1'b1;
            end
        end
    end

    // Two-flop synchronizer for the asynchronous ADC busy line.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
        end else begin
            r_busy_meta <= adc_busy;
            r_busy_sync <= r_busy_meta;
        end
    end

    // State register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= StIdle;
        else          r_state <= w_state_d;
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:     if (w_start_ok) w_state_d = StSelect;
            StSelect:   w_state_d = StSettle;
            StSettle:   if (r_cnt == '0) w_state_d = StConvst;
            StConvst:   if (r_cnt == '0) w_state_d = StWaitBusy;
            StWaitBusy: begin
                if (w_busy_done)        w_state_d = StRead;
                else if (w_timeout_hit) w_state_d = StIdle;
            end
            StRead:     if (r_cnt == '0) w_state_d = StPush;
            StPush:     if (m_ready) w_state_d = StNext;
            StNext:     w_state_d = w_finish ? StIdle : StSelect;
            default:    w_state_d = StIdle;
        endcase
    end

    // Phase counter: settle countdown, convst width, wait-busy age, read width.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cnt <= '0;
        end else begin
            unique case (r_state)
                StSelect:   r_cnt <= {{(CNT_W-8){1'b0}}, r_settle};
                StSettle:   r_cnt <= (r_cnt == '0) ? C_CONVST_LAST : r_cnt - 1'b1;
                StConvst:   r_cnt <= (r_cnt == '0) ? '0 : r_cnt - 1'b1;
                StWaitBusy: r_cnt <= w_busy_done ? C_RD_LAST : r_cnt + 1'b1;
                StRead:     if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                default:    r_cnt <= r_cnt;
            endcase
        end
    end

    // Run configuration, channel pointer, stop latch and frame counter.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_mask      <= '0;
            r_frames    <= '0;
            r_settle    <= '0;
            r_ch        <= '0;
            r_stop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_mask   <= cfg_ch_mask;
                r_frames <= cfg_frames;
                r_settle <= cfg_settle;
                r_ch     <= w_cfg_first;
            end else if ((r_state == StNext) && !w_finish) begin
                r_ch <= w_is_last ? w_first : w_next;
            end

            if (w_start_ok)                            r_stop <= 1'b0;
            else if ((r_state != StIdle) && cfg_stop)  r_stop <= 1'b1;

            if (w_start_ok || w_start_empty)           r_frame_cnt <= '0;
            else if ((r_state == StNext) && w_is_last) r_frame_cnt <= w_frame_inc;
        end
    end

    // Output next values, derived from the upcoming state so outputs stay registered.
    always_comb begin
        w_convst_d  = (w_state_d == StConvst);
        w_rd_n_d    = (w_state_d != StRead);
        w_valid_d   = (w_state_d == StPush);
        w_st_busy_d = (w_state_d != StIdle);
        w_done_d    = r_done;
        w_timeout_d = r_timeout;
        w_mdata_d   = r_mdata;
        if (w_start_empty) begin
            w_done_d    = 1'b1;
            w_timeout_d = 1'b0;
        end else if (w_start_ok) begin
            w_done_d    = 1'b0;
            w_timeout_d = 1'b0;
        end else if ((r_state != StIdle) && (w_state_d == StIdle)) begin
            w_done_d = 1'b1;
            if (r_state == StWaitBusy) w_timeout_d = 1'b1;
        end
        if ((r_state == StRead) && (r_cnt == '0)) begin
            w_mdata_d = {w_is_last, r_ch, adc_data};
        end
    end

    // Output registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_convst  <= 1'b0;
            r_rd_n    <= 1'b1;
            r_valid   <= 1'b0;
            r_st_busy <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_mdata   <= '0;
        end else begin
            r_convst  <= w_convst_d;
            r_rd_n    <= w_rd_n_d;
            r_valid   <= w_valid_d;
            r_st_busy <= w_st_busy_d;
            r_done    <= w_done_d;
            r_timeout <= w_timeout_d;
            r_mdata   <= w_mdata_d;
        end
    end

    assign adc_ch       = r_ch;
    assign adc_convst   = r_convst;
    assign adc_rd_n     = r_rd_n;
    assign m_valid      = r_valid;
    assign m_data       = r_mdata;
    assign st_busy      = r_st_busy;
    assign st_done      = r_done;
    assign st_timeout   = r_timeout;
    assign st_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// Scoreboard bench for adc_seq_ctrl with a simple behavioural SAR ADC model.
module tb_adc_seq_ctrl;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned NCH    = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned MW     = DATA_W + CH_W + 1;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              cfg_start = 1'b0;
    logic              cfg_stop = 1'b0;
    logic [NCH-1:0]    cfg_ch_mask = '0;
    logic [15:0]       cfg_frames = '0;
    logic [7:0]        cfg_settle = '0;
    logic [CH_W-1:0]   adc_ch;
    logic              adc_convst;
    logic              adc_busy = 1'b0;
    logic              adc_rd_n;
    logic [DATA_W-1:0] adc_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [MW-1:0]     m_data;
    logic              st_busy, st_done, st_timeout;
    logic [15:0]       st_frame_cnt;

    adc_seq_ctrl dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_ch_mask  (cfg_ch_mask),
        .cfg_frames   (cfg_frames),
        .cfg_settle   (cfg_settle),
        .adc_ch       (adc_ch),
        .adc_convst   (adc_convst),
        .adc_busy     (adc_busy),
        .adc_rd_n     (adc_rd_n),
        .adc_data     (adc_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .st_busy      (st_busy),
        .st_done      (st_done),
        .st_timeout   (st_timeout),
        .st_frame_cnt (st_frame_cnt)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_conv   = 0;
    int n_rd_low = 0;
    logic [MW-1:0] exp_q[$];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ADC model: data depends on the mux channel, busy follows convst plus a tail.
    bit data_ovr_en = 1'b0;
    bit busy_stuck  = 1'b0;
    int busy_len    = 10;
    int busy_cnt    = 0;
    assign adc_data = data_ovr_en ? 12'hABC : (12'h5A0 + 12'(adc_ch));

    always @(posedge ACLK) begin
        #1;
        if (busy_stuck) adc_busy = 1'b1;
        else if (adc_convst) begin
            adc_busy = 1'b1;
            busy_cnt = busy_len;
        end else if (busy_cnt != 0) busy_cnt--;
        else adc_busy = 1'b0;
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    bit            prev_valid = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0, prev_convst = 1'b0;
    logic [MW-1:0] prev_data = '0;
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_valid  = 1'b0;
            prev_busy   = 1'b0;
            prev_convst = 1'b0;
        end else begin
            if (prev_valid && !prev_ready)
                check_eq("valid_hold", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
            if (m_valid && m_ready) begin
                n_push++;
                if (exp_q.size() == 0) check_eq("unexpected_push", 32'(m_data), 32'hFFFF_FFFF);
                else check_eq("push_data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (prev_busy && !st_busy) check_eq("done_at_busy_fall", 32'(st_done), 32'd1);
            if (adc_convst && !prev_convst) n_conv++;
            if (!adc_rd_n) n_rd_low++;
            prev_valid  = m_valid;
            prev_ready  = m_ready;
            prev_data   = m_data;
            prev_busy   = st_busy;
            prev_convst = adc_convst;
        end
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic start_run(input logic [7:0] mask, input logic [15:0] frames,
                             input logic [7:0] settle);
        @(negedge ACLK);
        cfg_ch_mask = mask;
        cfg_frames  = frames;
        cfg_settle  = settle;
        cfg_start   = 1'b1;
        @(posedge ACLK);
        #1;
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc, input string name);
        int n = 0;
        while (st_busy && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(name, 32'(st_busy), 32'd0);
    endtask

    task automatic wait_convst(input int max_cyc, output int n);
        n = 0;
        while (!adc_convst && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, m, c0, p0, r0;
        bit seen_low;

        repeat (3) @(posedge ACLK);
        #1;
        check_eq("rst_ctrl", 32'({adc_ch, adc_convst, adc_rd_n, m_valid, st_busy, st_done,
                                  st_timeout}), 32'({3'd0, 6'b010000}));
        check_eq("rst_mdata", 32'(m_data), 32'd0);
        check_eq("rst_frames", 32'(st_frame_cnt), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) tick();

        // Mask 0x05, two frames, settle 3; config changed after start must be ignored.
        busy_len = 10;
        exp_q.push_back({1'b0, 3'd0, 12'h5A0});
        exp_q.push_back({1'b1, 3'd2, 12'h5A2});
        exp_q.push_back({1'b0, 3'd0, 12'h5A0});
        exp_q.push_back({1'b1, 3'd2, 12'h5A2});
        p0 = n_push;
        start_run(8'h05, 16'd2, 8'd3);
        check_eq("t1_busy_set", 32'(st_busy), 32'd1);
        cfg_ch_mask = 8'hFF;
        cfg_frames  = 16'd7;
        cfg_settle  = 8'd40;
        wait_convst(50, n);
        check_eq("t1_start_to_convst", 32'(n), 32'd5);
        wait_idle(2000, "t1_finish");
        check_eq("t1_status", 32'({st_done, st_timeout, st_frame_cnt}), 32'({2'b10, 16'd2}));
        check_eq("t1_push_count", 32'(n_push - p0), 32'd4);

        // Minimum per-sample period with settle 0 and busy low right after blanking.
        busy_len = 0;
        exp_q.push_back({1'b0, 3'd0, 12'h5A0});
        exp_q.push_back({1'b1, 3'd1, 12'h5A1});
        start_run(8'h03, 16'd1, 8'd0);
        wait_convst(50, n);
        check_eq("t1b_start_to_convst", 32'(n), 32'd2);
        m = 0;
        seen_low = 1'b0;
        while (m < 100) begin
            tick();
            m++;
            if (!adc_convst) seen_low = 1'b1;
            if (seen_low && adc_convst) break;
        end
        check_eq("t1b_sample_period", 32'(m), 32'd14);
        wait_idle(200, "t1b_finish");
        check_eq("t1b_frames", 32'(st_frame_cnt), 32'd1);

        // Backpressure on channel 7 with fixed data.
        busy_len    = 2;
        data_ovr_en = 1'b1;
        m_ready     = 1'b0;
        exp_q.push_back({1'b1, 3'd7, 12'hABC});
        p0 = n_push;
        start_run(8'h80, 16'd1, 8'd0);
        n = 0;
        while (!m_valid && n < 100) begin
            tick();
            n++;
        end
        check_eq("t2_valid_seen", 32'(m_valid), 32'd1);
        repeat (20) tick();
        check_eq("t2_stalled_word", 32'({m_valid, m_data}), 32'({1'b1, 16'hFABC}));
        check_eq("t2_no_push_yet", 32'(n_push - p0), 32'd0);
        m_ready = 1'b1;
        wait_idle(100, "t2_finish");
        check_eq("t2_push_count", 32'(n_push - p0), 32'd1);
        data_ovr_en = 1'b0;

        // Busy stuck high: abort after TIMEOUT wait cycles with no read and no push.
        busy_stuck = 1'b1;
        repeat (4) tick();
        p0 = n_push;
        r0 = n_rd_low;
        start_run(8'h01, 16'd1, 8'd0);
        wait_convst(50, n);
        n = 0;
        while (st_busy && n < 1200) begin
            tick();
            n++;
        end
        check_eq("t3_convst_to_abort", 32'(n), 32'd1025);
        check_eq("t3_status", 32'({st_done, st_timeout}), 32'b11);
        check_eq("t3_no_read", 32'(n_rd_low - r0), 32'd0);
        check_eq("t3_no_push", 32'(n_push - p0), 32'd0);
        busy_stuck = 1'b0;
        repeat (5) tick();

        // Continuous run, stop during the channel 0 conversion.
        busy_len = 10;
        exp_q.push_back({1'b0, 3'd0, 12'h5A0});
        c0 = n_conv;
        start_run(8'h03, 16'd0, 8'd2);
        check_eq("t4_timeout_cleared", 32'(st_timeout), 32'd0);
        wait_convst(50, n);
        @(negedge ACLK);
        cfg_stop = 1'b1;
        @(posedge ACLK);
        #1;
        cfg_stop = 1'b0;
        wait_idle(500, "t4_finish");
        check_eq("t4_conversions", 32'(n_conv - c0), 32'd1);
        check_eq("t4_status", 32'({st_done, st_frame_cnt}), 32'({1'b1, 16'd0}));

        // Asynchronous reset in the middle of READ.
        busy_len = 0;
        start_run(8'h01, 16'd1, 8'd0);
        n = 0;
        while (adc_rd_n && n < 100) begin
            tick();
            n++;
        end
        check_eq("t5_in_read", 32'(adc_rd_n), 32'd0);
        #2;
        ARESETN = 1'b0;
        #1;
        check_eq("t5_async_reset", 32'({adc_rd_n, m_valid, st_busy, adc_convst, st_done}),
                 32'b10000);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        exp_q.push_back({1'b1, 3'd1, 12'h5A1});
        start_run(8'h02, 16'd1, 8'd0);
        wait_idle(200, "t5_rerun_finish");
        check_eq("t5_rerun_status", 32'({st_done, st_frame_cnt}), 32'({1'b1, 16'd1}));

        // Empty mask finishes at once; a start during a run is ignored.
        c0 = n_conv;
        start_run(8'h00, 16'd3, 8'd0);
        check_eq("t6_empty_status", 32'({st_done, st_busy, st_frame_cnt}), 32'({2'b10, 16'd0}));
        repeat (10) tick();
        check_eq("t6_empty_no_conv", 32'(n_conv - c0), 32'd0);
        busy_len = 2;
        exp_q.push_back({1'b0, 3'd0, 12'h5A0});
        exp_q.push_back({1'b1, 3'd2, 12'h5A2});
        start_run(8'h05, 16'd1, 8'd0);
        check_eq("t6_done_cleared", 32'(st_done), 32'd0);
        wait_convst(50, n);
        start_run(8'h02, 16'd1, 8'd0);
        wait_idle(300, "t6_finish");
        check_eq("t6_status", 32'({st_done, st_frame_cnt}), 32'({1'b1, 16'd1}));
        check_eq("t6_conversions", 32'(n_conv - c0), 32'd2);

        repeat (5) tick();
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

Conversion sequencer for the measurement front-end ADC. It sits between the AXI4-Lite register bank of the ADC IP and an external parallel-output SAR ADC with an analog input multiplexer. It scans the enabled channels in ascending order, handles the CONVST/BUSY/RD handshake, and streams the tagged results out over a valid/ready interface. It also reports busy, done, timeout and frame-count status back to the register bank.

## Interface
Parameters:
- DATA_W, 12, ADC result width
- NCH, 8, number of mux channels (CH_W = clog2(NCH))
- CONVST_CYCLES, 2, width of the convst pulse in ACLK cycles
- BLANK_CYCLES, 4, number of cycles adc_busy is ignored after convst falls
- RD_CYCLES, 3, width of the adc_rd_n low pulse; data is sampled on its last cycle
- TIMEOUT, 1023, maximum number of WAIT_BUSY cycles before abort

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- cfg_start  in  1  one-cycle pulse that starts a run
- cfg_stop  in  1  one-cycle pulse that requests a stop at the next channel boundary
- cfg_ch_mask  in  NCH  channel enable mask
- cfg_frames  in  16  number of frames per run; 0 means continuous
- cfg_settle  in  8  mux settle time in cycles
- adc_ch  out  CH_W  mux select
- adc_convst  out  1  start of conversion, active high
- adc_busy  in  1  asynchronous ADC busy
- adc_rd_n  out  1  read strobe, active low
- adc_data  in  DATA_W  parallel ADC data
- m_valid  out  1  result valid
- m_ready  in  1  result accepted
- m_data  out  DATA_W+CH_W+1  result word, {last_of_frame, ch, sample}
- st_busy  out  1  run in progress
- st_done  out  1  sticky; cleared by cfg_start
- st_timeout  out  1  sticky; cleared by cfg_start
- st_frame_cnt  out  16  completed frames in the current run

## Operation
- adc_busy passes through a 2-FF synchronizer before use.
- The state machine has states IDLE, SELECT, SETTLE, CONVST, WAIT_BUSY, READ, PUSH and NEXT.
- IDLE: cfg_start clears st_done, st_timeout and st_frame_cnt.
  - If cfg_ch_mask != 0, latch the mask, frames and settle configuration, set st_busy, and go to SELECT with ch = lowest set bit.
  - If cfg_ch_mask == 0, set st_done the next cycle and perform no conversions.
- SELECT: drive adc_ch = ch and load the settle counter, then go to SETTLE.
- SETTLE: wait cfg_settle cycles (0 means no wait), then go to CONVST.
- CONVST: hold adc_convst high for CONVST_CYCLES, then go to WAIT_BUSY.
- WAIT_BUSY: ignore busy for BLANK_CYCLES, then wait for synced busy == 0 and go to READ.
  - If the cycle count since entry reaches TIMEOUT: set st_timeout and st_done, clear st_busy, and go to IDLE without a push.
- READ: drive adc_rd_n low for RD_CYCLES. Capture adc_data on the last low cycle, then release rd_n and go to PUSH.
- PUSH: m_valid = 1 with m_data stable until m_ready. last_of_frame = 1 when ch is the highest enabled channel.
- NEXT: advance to the next higher enabled channel and go to SELECT.
  - After the highest enabled channel, increment st_frame_cnt. If st_frame_cnt == cfg_frames (with cfg_frames != 0), finish; otherwise wrap to the lowest enabled channel.
- cfg_stop received during a run is latched. It takes effect in NEXT: the current sample is always pushed first, then the run finishes. st_frame_cnt counts only complete frames.
- Finishing a run means: clear st_busy, set st_done, go to IDLE.
- cfg_start while st_busy is ignored. Configuration inputs are used only as latched at start.
- st_frame_cnt saturates at 0xFFFF in continuous mode.

## Timing
- Reset values: adc_ch = 0, adc_convst = 0, adc_rd_n = 1, m_valid = 0, m_data = 0, all st_* = 0, state = IDLE.
- Reset is asynchronous and may occur mid-operation. Outputs return to reset values immediately, with no partial push and no final convst.
- All outputs are registered.
- From cfg_start to the adc_convst rise: 2 + cfg_settle cycles.
- Minimum per-sample cycle count, with busy low after blanking and m_ready held high: 2 + cfg_settle + CONVST_CYCLES + BLANK_CYCLES + 1 + RD_CYCLES + 1 + 1.
- m_valid never drops without m_ready. Backpressure stalls the sequencer in PUSH; no samples are dropped.
- st_done rises in the same cycle that st_busy falls.

## Test plan
- Mask 0x05, frames 2, settle 3, busy low 10 cycles after convst, m_ready = 1 -> 4 pushes, ch 0,2,0,2, last flag 0,1,0,1, st_frame_cnt = 2, st_done = 1.
- Mask 0x80, adc_data = 0xABC, m_ready held low for 20 cycles -> m_valid held with m_data = {1,3'd7,12'hABC} stable; one push on release.
- adc_busy stuck high -> st_timeout = 1 and st_done = 1 after TIMEOUT WAIT_BUSY cycles, no m_valid, adc_rd_n never low.
- Continuous run with mask 0x03, cfg_stop during ch 0 conversion -> ch 0 sample pushed, no ch 1 conversion, st_frame_cnt unchanged.
- ARESETN low during READ -> adc_rd_n = 1, m_valid = 0, st_busy = 0 asynchronously; cfg_start after release runs normally.
- cfg_start with mask 0, and a second cfg_start during a run -> done with no conversions in the first case; the second start is ignored and the frame count is unaffected.
